// File: rtl/mm_seq.sv
// mm_seq: Wishbone-master sequencer that feeds one 4x4 matrix-multiply job
// (16 B words then 16 A words) from SRAM into the mm accelerator, waits for
// completion, and copies the 16 results back into SRAM.
module mm_seq #(
   parameter logic [31:0] MM_WR_ADDR = 32'h3830_0000,
   parameter logic [31:0] MM_RD_ADDR = 32'h3830_0010,
   parameter int          AW         = 12,
   parameter int          TIMEOUT    = 255
) (
   input  logic          wb_clk_i,
   input  logic          wb_rst_i,
   input  logic          start_i,
   input  logic [AW-1:0] src_base_i,
   input  logic [AW-1:0] dst_base_i,
   output logic          mem_en_o,
   output logic          mem_we_o,
   output logic [AW-1:0] mem_addr_o,
   output logic [31:0]   mem_wdata_o,
   input  logic [31:0]   mem_rdata_i,
   output logic          wbm_cyc_o,
   output logic          wbm_stb_o,
   output logic          wbm_we_o,
   output logic [3:0]    wbm_sel_o,
   output logic [31:0]   wbm_adr_o,
   output logic [31:0]   wbm_dat_o,
   input  logic          wbm_ack_i,
   input  logic [31:0]   wbm_dat_i,
   input  logic          mm_ready_i,
   input  logic          mm_done_i,
   output logic          busy_o,
   output logic          done_o,
   output logic          err_o
);

   localparam int TW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

   localparam logic [3:0] S_IDLE      = 4'd0;
   localparam logic [3:0] S_WAIT_RDY  = 4'd1;
   localparam logic [3:0] S_MEM_RD    = 4'd2;
   localparam logic [3:0] S_MEM_LAT   = 4'd3;
   localparam logic [3:0] S_MM_WR     = 4'd4;
   localparam logic [3:0] S_GAP       = 4'd5;
   localparam logic [3:0] S_WAIT_DONE = 4'd6;
   localparam logic [3:0] S_MM_RD     = 4'd7;
   localparam logic [3:0] S_MEM_WR    = 4'd8;
   localparam logic [3:0] S_DONE      = 4'd9;
   localparam logic [3:0] S_ERR       = 4'd10;

   logic [3:0]    state_q,   state_d;
   logic [4:0]    in_cnt_q,  in_cnt_d;
   logic [3:0]    out_cnt_q, out_cnt_d;
   logic [TW-1:0] tcnt_q,    tcnt_d;
   logic [AW-1:0] src_q,     src_d;
   logic [AW-1:0] dst_q,     dst_d;
   logic [31:0]   wdat_q,    wdat_d;
   logic [31:0]   rdat_q,    rdat_d;
   logic          done_q,    done_d;
   logic          err_q,     err_d;
   logic          timed_state;
   logic          tmo_hit;

   // Next-state, counters and data capture for the job sequence
   always_comb begin
      state_d   = state_q;
      in_cnt_d  = in_cnt_q;
      out_cnt_d = out_cnt_q;
      src_d     = src_q;
      dst_d     = dst_q;
      wdat_d    = wdat_q;
      rdat_d    = rdat_q;
      done_d    = done_q;
      err_d     = err_q;
      tmo_hit   = (tcnt_q == TW'(TIMEOUT));
      timed_state = (state_q == S_WAIT_RDY) || (state_q == S_MM_WR) ||
                    (state_q == S_WAIT_DONE) || (state_q == S_MM_RD);
      case (state_q)
         S_IDLE, S_DONE, S_ERR: begin
            if (start_i) begin
               src_d     = src_base_i;
               dst_d     = dst_base_i;
               done_d    = 1'b0;
               err_d     = 1'b0;
               in_cnt_d  = '0;
               out_cnt_d = '0;
               state_d   = S_WAIT_RDY;
            end
         end
         S_WAIT_RDY: begin
            if (mm_ready_i)   state_d = S_MEM_RD;
            else if (tmo_hit) begin state_d = S_ERR; err_d = 1'b1; end
         end
         S_MEM_RD:  state_d = S_MEM_LAT;
         S_MEM_LAT: begin
            wdat_d  = mem_rdata_i;
            state_d = S_MM_WR;
         end
         // ack is checked before the timeout so a last-cycle ack still counts
         S_MM_WR: begin
            if (wbm_ack_i)    state_d = S_GAP;
            else if (tmo_hit) begin state_d = S_ERR; err_d = 1'b1; end
         end
         // strobe-low cycle: mm latches on rising strobe edges
         S_GAP: begin
            in_cnt_d = in_cnt_q + 5'd1;
            state_d  = (in_cnt_q == 5'd31) ? S_WAIT_DONE : S_MEM_RD;
         end
         S_WAIT_DONE: begin
            if (mm_done_i)    state_d = S_MM_RD;
            else if (tmo_hit) begin state_d = S_ERR; err_d = 1'b1; end
         end
         // leave on the first ack so mm sees exactly one acked cycle per result
         S_MM_RD: begin
            if (wbm_ack_i) begin
               rdat_d  = wbm_dat_i;
               state_d = S_MEM_WR;
            end else if (tmo_hit) begin
               state_d = S_ERR;
               err_d   = 1'b1;
            end
         end
         S_MEM_WR: begin
            out_cnt_d = out_cnt_q + 4'd1;
            if (out_cnt_q == 4'd15) begin
               state_d = S_DONE;
               done_d  = 1'b1;
            end else begin
               state_d = S_MM_RD;
            end
         end
         default: state_d = S_IDLE;
      endcase
      // any state change (including MEM_WR -> MM_RD re-entry) restarts the timer
      if (state_d != state_q) tcnt_d = '0;
      else if (timed_state)   tcnt_d = tcnt_q + TW'(1);
      else                    tcnt_d = tcnt_q;
   end

   // State and datapath registers with synchronous reset
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         state_q   <= S_IDLE;
         in_cnt_q  <= '0;
         out_cnt_q <= '0;
         tcnt_q    <= '0;
         src_q     <= '0;
         dst_q     <= '0;
         wdat_q    <= '0;
         rdat_q    <= '0;
         done_q    <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         in_cnt_q  <= in_cnt_d;
         out_cnt_q <= out_cnt_d;
         tcnt_q    <= tcnt_d;
         src_q     <= src_d;
         dst_q     <= dst_d;
         wdat_q    <= wdat_d;
         rdat_q    <= rdat_d;
         done_q    <= done_d;
         err_q     <= err_d;
      end
   end

   // Bus and SRAM outputs decoded from the current state; idle values are 0
   always_comb begin
      mem_en_o    = 1'b0;
      mem_we_o    = 1'b0;
      mem_addr_o  = '0;
      mem_wdata_o = '0;
      wbm_stb_o   = 1'b0;
      wbm_we_o    = 1'b0;
      wbm_adr_o   = '0;
      wbm_dat_o   = '0;
      case (state_q)
         S_MEM_RD: begin
            mem_en_o   = 1'b1;
            mem_addr_o = src_q + AW'(in_cnt_q);
         end
         S_MM_WR: begin
            wbm_stb_o = 1'b1;
            wbm_we_o  = 1'b1;
            wbm_adr_o = MM_WR_ADDR;
            wbm_dat_o = wdat_q;
         end
         S_MM_RD: begin
            wbm_stb_o = 1'b1;
            wbm_adr_o = MM_RD_ADDR;
         end
         S_MEM_WR: begin
            mem_en_o    = 1'b1;
            mem_we_o    = 1'b1;
            mem_addr_o  = dst_q + AW'(out_cnt_q);
            mem_wdata_o = rdat_q;
         end
         default: ;
      endcase
      wbm_cyc_o = wbm_stb_o;
      wbm_sel_o = 4'hF;
      busy_o    = (state_q != S_IDLE) && (state_q != S_DONE) && (state_q != S_ERR);
      done_o    = done_q;
      err_o     = err_q;
   end

endmodule

// File: tb/tb_mm_seq.sv
// tb_mm_seq: scoreboard bench for mm_seq with a behavioural SRAM and mm slave.
module tb_mm_seq;
   localparam int AW      = 12;
   localparam int TIMEOUT = 255;

   logic          clk = 1'b0;
   logic          rst;
   logic          start_i;
   logic [AW-1:0] src_base_i, dst_base_i;
   logic          mem_en_o, mem_we_o;
   logic [AW-1:0] mem_addr_o;
   logic [31:0]   mem_wdata_o, mem_rdata_i;
   logic          wbm_cyc_o, wbm_stb_o, wbm_we_o;
   logic [3:0]    wbm_sel_o;
   logic [31:0]   wbm_adr_o, wbm_dat_o, wbm_dat_i;
   logic          wbm_ack_i, mm_ready_i, mm_done_i;
   logic          busy_o, done_o, err_o;

   always #5 clk = ~clk;

   mm_seq #(.AW(AW), .TIMEOUT(TIMEOUT)) dut (
      .wb_clk_i(clk), .wb_rst_i(rst), .start_i(start_i),
      .src_base_i(src_base_i), .dst_base_i(dst_base_i),
      .mem_en_o(mem_en_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
      .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i),
      .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o), .wbm_we_o(wbm_we_o),
      .wbm_sel_o(wbm_sel_o), .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o),
      .wbm_ack_i(wbm_ack_i), .wbm_dat_i(wbm_dat_i),
      .mm_ready_i(mm_ready_i), .mm_done_i(mm_done_i),
      .busy_o(busy_o), .done_o(done_o), .err_o(err_o));

   int checks = 0;
   int errors = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // ---------------- SRAM model (one-cycle read latency, bench preload port)
   logic [31:0]   sram [0:4095];
   logic          pre_we;
   logic [AW-1:0] pre_addr;
   logic [31:0]   pre_data;

   always @(posedge clk) begin
      if (pre_we) sram[pre_addr] <= pre_data;
      else if (mem_en_o && mem_we_o) sram[mem_addr_o] <= mem_wdata_o;
      if (mem_en_o && !mem_we_o) mem_rdata_i <= sram[mem_addr_o];
   end

   // ---------------- mm model: latches a word per rising write strobe,
   // one-cycle ack, result index advances on every acked read
   logic        mm_rst, ready_en, ack_q, mm_prev, mm_done;
   logic [31:0] mm_in [0:31];
   int          mm_wcnt, mm_ridx;

   always @(posedge clk) begin
      if (mm_rst) begin
         mm_wcnt <= 0; mm_ridx <= 0; mm_prev <= 1'b0; ack_q <= 1'b0; mm_done <= 1'b0;
      end else begin
         mm_prev <= wbm_stb_o & wbm_we_o;
         if (wbm_stb_o && wbm_we_o && !mm_prev) begin
            if (mm_wcnt < 32) mm_in[mm_wcnt] <= wbm_dat_o;
            mm_wcnt <= mm_wcnt + 1;
         end
         ack_q   <= wbm_cyc_o & wbm_stb_o & ~ack_q;
         mm_done <= (mm_wcnt == 32);
         if (ack_q && !wbm_we_o) mm_ridx <= mm_ridx + 1;
      end
   end

   // C = A x B with B = words 0..15, A = words 16..31 (row-major)
   always_comb begin
      int ri, rj;
      ri = (mm_ridx / 4) % 4;
      rj = mm_ridx % 4;
      wbm_dat_i = '0;
      if (ack_q)
         for (int k = 0; k < 4; k++)
            wbm_dat_i = wbm_dat_i + mm_in[16 + ri*4 + k] * mm_in[k*4 + rj];
   end
   assign wbm_ack_i  = ack_q;
   assign mm_ready_i = ready_en;
   assign mm_done_i  = mm_done;

   // ---------------- directed vectors: B = I4, A = 1..16, so C = A = 1..16
   function automatic logic [31:0] in_word(input int i);
      if (i < 16) return (i % 5 == 0) ? 32'd1 : 32'd0;
      return 32'(i - 15);
   endfunction

   // ---------------- scoreboard queues
   logic [AW-1:0]    q_rd [$];   // expected SRAM read addresses
   logic [31:0]      q_mm [$];   // expected words seen by mm, in order
   logic [AW+31:0]   q_wr [$];   // expected {addr, data} SRAM writes
   int mm_seen  = 0;
   int activity = 0;

   task automatic push_job(input logic [AW-1:0] src, input logic [AW-1:0] dst);
      for (int i = 0; i < 32; i++) begin
         q_rd.push_back(src + AW'(i));
         q_mm.push_back(in_word(i));
      end
      for (int i = 0; i < 16; i++) q_wr.push_back({dst + AW'(i), 32'(i + 1)});
   endtask

   // monitor: pops and compares on every DUT SRAM access and mm write edge
   initial begin
      logic            prev_wr;
      logic [AW-1:0]   ea;
      logic [31:0]     ed;
      logic [AW+31:0]  ew;
      prev_wr = 1'b0;
      forever begin
         @(negedge clk);
         if (rst) begin
            prev_wr = 1'b0;
         end else begin
            if (wbm_stb_o || mem_en_o) activity++;
            if (wbm_stb_o && wbm_we_o && !prev_wr) begin
               mm_seen++;
               if (q_mm.size() == 0) chk("mm_wr_unexpected", {32'h0, wbm_dat_o}, 64'hFFFF_FFFF_FFFF_FFFF);
               else begin
                  ed = q_mm.pop_front();
                  chk("mm_wr_data", wbm_dat_o, ed);
                  chk("mm_wr_adr", wbm_adr_o, 32'h3830_0000);
               end
            end
            prev_wr = wbm_stb_o && wbm_we_o;
            if (wbm_stb_o && !wbm_we_o && wbm_adr_o !== 32'h3830_0010)
               chk("mm_rd_adr", wbm_adr_o, 32'h3830_0010);
            if (mem_en_o && !mem_we_o) begin
               if (q_rd.size() == 0) chk("sram_rd_unexpected", mem_addr_o, 64'hFFFF);
               else begin
                  ea = q_rd.pop_front();
                  chk("sram_rd_addr", mem_addr_o, ea);
               end
            end
            if (mem_en_o && mem_we_o) begin
               if (q_wr.size() == 0) chk("sram_wr_unexpected", mem_addr_o, 64'hFFFF);
               else begin
                  ew = q_wr.pop_front();
                  chk("sram_wr", {mem_addr_o, mem_wdata_o}, ew);
               end
            end
         end
      end
   end

   // ---------------- stimulus helpers
   task automatic load_sram(input logic [AW-1:0] src, input logic [AW-1:0] dst);
      for (int i = 0; i < 48; i++) begin
         @(negedge clk);
         pre_we   = 1'b1;
         pre_addr = (i < 32) ? src + AW'(i) : dst + AW'(i - 32);
         pre_data = (i < 32) ? in_word(i) : 32'hDEAD_0000;
      end
      @(negedge clk);
      pre_we = 1'b0;
   endtask

   task automatic check_zero(input string tag);
      chk({tag, "_busy"}, busy_o, 0);
      chk({tag, "_done"}, done_o, 0);
      chk({tag, "_err"}, err_o, 0);
      chk({tag, "_mem"}, {mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o}, 0);
      chk({tag, "_wb_ctl"}, {wbm_cyc_o, wbm_stb_o, wbm_we_o}, 0);
      chk({tag, "_wb_adr"}, wbm_adr_o, 0);
      chk({tag, "_wb_dat"}, wbm_dat_o, 0);
      chk({tag, "_sel"}, wbm_sel_o, 4'hF);
   endtask

   task automatic pulse_start(input logic [AW-1:0] src, input logic [AW-1:0] dst);
      @(negedge clk);
      start_i = 1'b1; src_base_i = src; dst_base_i = dst;
      @(negedge clk);
      start_i = 1'b0;
   endtask

   task automatic reset_mm();
      @(negedge clk); mm_rst = 1'b1;
      @(negedge clk); mm_rst = 1'b0;
   endtask

   // start (optionally in MM_WR / MM_RD) is poked with a bogus base to prove it is ignored
   task automatic poke_when(input logic want_we);
      int n = 0;
      while (!(wbm_stb_o && wbm_we_o == want_we) && n < 2000) begin @(negedge clk); n++; end
      chk(want_we ? "wait_mm_wr_budget" : "wait_mm_rd_budget", n < 2000, 1);
      start_i = 1'b1; src_base_i = 12'h555; dst_base_i = 12'h666;
      @(negedge clk);
      start_i = 1'b0;
   endtask

   task automatic run_job(input logic [AW-1:0] src, input logic [AW-1:0] dst, input bit poke);
      int n = 0;
      int seen0;
      load_sram(src, dst);
      reset_mm();
      push_job(src, dst);
      seen0 = mm_seen;
      pulse_start(src, dst);
      chk("start_busy", busy_o, 1);
      chk("start_done_clr", done_o, 0);
      chk("start_err_clr", err_o, 0);
      if (poke) begin
         poke_when(1'b1);
         poke_when(1'b0);
      end
      while (!done_o && !err_o && n < 3000) begin @(negedge clk); n++; end
      chk("job_budget", n < 3000, 1);
      @(negedge clk);
      chk("job_done", done_o, 1);
      chk("job_busy", busy_o, 0);
      chk("job_err", err_o, 0);
      chk("mm_rising_edges", mm_wcnt, 32);
      chk("mm_writes_seen", mm_seen - seen0, 32);
      chk("q_left", q_rd.size() + q_mm.size() + q_wr.size(), 0);
      for (int i = 0; i < 16; i++) chk("sram_result", sram[dst + AW'(i)], 32'(i + 1));
   endtask

   // ---------------- main sequence
   initial begin
      int n, seen0, act0;
      rst = 1'b1; start_i = 1'b0; src_base_i = '0; dst_base_i = '0;
      pre_we = 1'b0; pre_addr = '0; pre_data = '0;
      mm_rst = 1'b1; ready_en = 1'b1;
      repeat (3) @(negedge clk);
      check_zero("reset");
      rst = 1'b0; mm_rst = 1'b0;
      repeat (2) @(negedge clk);
      check_zero("idle");

      // basic job, write-strobe shape checked via mm edge count
      run_job(12'h100, 12'h200, 1'b0);

      // mm never ready: ERR after TIMEOUT+1 cycles with no bus/SRAM activity
      ready_en = 1'b0;
      reset_mm();
      act0 = activity;
      @(negedge clk);
      start_i = 1'b1; src_base_i = 12'h100; dst_base_i = 12'h200;
      @(posedge clk);
      @(negedge clk);
      start_i = 1'b0;
      n = 0;
      while (!err_o && n < 1000) begin @(posedge clk); n++; @(negedge clk); end
      chk("timeout_cycles", n, TIMEOUT + 1);
      chk("err_set", err_o, 1);
      chk("err_busy", busy_o, 0);
      chk("err_done", done_o, 0);
      repeat (3) @(negedge clk);
      chk("err_held", err_o, 1);
      chk("err_no_activity", activity - act0, 0);
      ready_en = 1'b1;
      run_job(12'h100, 12'h200, 1'b0);

      // reset in the middle of write 10
      load_sram(12'h100, 12'h200);
      reset_mm();
      push_job(12'h100, 12'h200);
      seen0 = mm_seen;
      pulse_start(12'h100, 12'h200);
      n = 0;
      while (!(mm_seen - seen0 == 10 && wbm_stb_o) && n < 2000) begin @(negedge clk); n++; end
      chk("wait_write10_budget", n < 2000, 1);
      rst = 1'b1; mm_rst = 1'b1;
      @(negedge clk);
      check_zero("midjob_rst");
      q_rd.delete(); q_mm.delete(); q_wr.delete();
      rst = 1'b0; mm_rst = 1'b0;
      repeat (3) @(negedge clk);
      check_zero("post_rst_idle");
      run_job(12'h100, 12'h200, 1'b0);

      // start pulses while busy are ignored
      run_job(12'h100, 12'h200, 1'b1);

      // source address wraps past 0xFFF
      run_job(12'hFF0, 12'h300, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
